fifo_rr_writer_arb: RTL and testbench
=====================================

// Module: fifo_rr_writer_arb
// PURPOSE
//  Round-robin arbiter sharing one myfifo write port between N requesters.
//  Each requester presents valid/data/last. A grant is held for a burst, ended
//  by last, by MAX_BURST words, or by the requester going idle. Each enqueued
//  word is tagged with its source ID so the consumer can demultiplex. Sits
//  directly in front of a myfifo instance of width WIDTH+IDW.
// PARAMETERS
//  N          4   number of requesters (>=2)
//  WIDTH      32  payload width per requester
//  MAX_BURST  8   max words per grant (>=1)
//  IDW        $clog2(N)  derived (localparam), source-ID tag width
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  req_valid  in   N            requester i has a word
//  req_data   in   N*WIDTH      requester i payload at [i*WIDTH +: WIDTH]
//  req_last   in   N            word is last of requester i packet
//  req_ready  out  N            word of requester i accepted this cycle when valid&ready
//  fifo_enq   out  1            enqueue strobe to myfifo
//  fifo_din   out  WIDTH+IDW    {grant_id, payload} to myfifo
//  fifo_full  in   1            myfifo full
//  grant_id   out  IDW          currently granted requester (registered)
//  busy       out  1            1 while in LOCK
// BEHAVIOUR
//  - State regs: state{IDLE,LOCK}, rr_ptr[IDW], grant_id[IDW], burst_cnt.
//  - Reset: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
//    req_ready=0, fifo_enq=0, busy=0, fifo_din=0.
//    While rst=1, all outputs are forced 0 combinationally.
//  - IDLE: if |req_valid, pick the first i with req_valid[i], searching
//    rr_ptr, rr_ptr+1, ... N-1, 0, ... (mod N). grant_id<=i, burst_cnt<=0,
//    state<=LOCK. No transfer occurs in the IDLE cycle (1-cycle grant latency).
//    If no requester is valid, stay in IDLE.
//  - LOCK, g=grant_id:
//    - req_ready[g] = !fifo_full; req_ready[j!=g] = 0.
//    - xfer = req_valid[g] & !fifo_full. fifo_enq = xfer (combinational).
//    - fifo_din = {g, req_data[g]}; value is don't-care when !fifo_enq
//      (drive 0).
//    - On xfer: burst_cnt<=burst_cnt+1.
//  - Release (LOCK->IDLE, rr_ptr<=(g+1) mod N, burst_cnt<=0) on any of:
//    - xfer & req_last[g]
//    - xfer & burst_cnt==MAX_BURST-1
//    - !req_valid[g] (requester idle for a cycle in LOCK; no transfer)
//  - fifo_full in LOCK: grant is held, burst_cnt is frozen, no release for
//    the stall itself. A stall does not time out.
//  - Fairness: after a release, the released requester has lowest priority.
//    Any continuously-valid requester is granted within N grants.
//  - Next grant starts earliest 1 cycle after release (IDLE cycle).
//    Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
//  - Requesters must hold data/last stable while valid&!ready. The arbiter
//    does not check this.
//  - Reset mid-burst: burst abandoned, rr_ptr=0, no enq in the reset cycle.
//    Any partially written packet stays in the FIFO; the consumer resyncs
//    by tag/last.
//  - burst_cnt width: $clog2(MAX_BURST+1). Never exceeds MAX_BURST-1 while
//    in LOCK.
// TESTING
//  1 reset: rst=1 for 2 cycles with all valid=1 -> fifo_enq=0, req_ready=0,
//    busy=0. After rst falls, first grant_id=0.
//  2 single: req0 sends 3 words, last on word 3, fifo never full ->
//    IDLE 1 cycle, then 3 consecutive enq of {0,data}, then busy=0.
//  3 burst cap: MAX_BURST=8, req1 sends 20 words with no last and only req1
//    valid -> enq pattern 8 on / 1 off / 8 on / 1 off / 4 on.
//    grant_id stays 1.
//  4 round-robin: all 4 valid, 1-word packets with last=1 ->
//    grant order 0,1,2,3,0,1. Tags in FIFO match.
//  5 full stall: fifo_full=1 for 5 cycles mid-burst of req2 -> no enq,
//    req_ready=0, grant held. Resumes with the next word and no loss or
//    duplication. burst_cnt unchanged across the stall.
//  6 idle drop + mid-reset: req3 drops valid after 2 words -> release, next
//    requester granted. Assert rst mid-burst -> state IDLE, rr_ptr=0, no
//    spurious enq.

Source files
------------

// File: rtl/fifo_rr_writer_arb.sv
// Round-robin arbiter that shares one FIFO write port between N requesters.
// Each granted burst is tagged with the source ID so the consumer can demultiplex it.
module fifo_rr_writer_arb #(
    parameter  int N         = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 8,
    localparam int IDW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_req_valid,
    input  logic [N*WIDTH-1:0]   i_req_data,
    input  logic [N-1:0]         i_req_last,
    output logic [N-1:0]         o_req_ready,
    output logic                 o_fifo_enq,
    output logic [WIDTH+IDW-1:0] o_fifo_din,
    input  logic                 i_fifo_full,
    output logic [IDW-1:0]       o_grant_id,
    output logic                 o_busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   w_rr_nxt;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   w_grant_nxt;
    logic [CW-1:0]    r_burst_cnt;
    logic [CW-1:0]    w_burst_nxt;

    logic             w_g_valid;
    logic             w_g_last;
    logic [WIDTH-1:0] w_g_data;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_pick;
    logic [IDW-1:0]   w_rr_inc;
    logic             w_xfer;

    // Select the granted requester's valid/last/data.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            w_g_valid = (r_grant_id == IDW'(i)) ? i_req_valid[i] : w_g_valid;
            w_g_last  = (r_grant_id == IDW'(i)) ? i_req_last[i]  : w_g_last;
            w_g_data  = (r_grant_id == IDW'(i)) ? i_req_data[i*WIDTH +: WIDTH] : w_g_data;
        end
    end

    // Rotating priority search; walking from the far end lets the nearest candidate win.
    always_comb begin
        w_cand = {IDW{1'b0}};
        w_pick = {IDW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % N);
            w_pick = i_req_valid[w_cand] ? w_cand : w_pick;
        end
        w_rr_inc = (r_grant_id == IDW'(N - 1)) ? {IDW{1'b0}} : IDW'(r_grant_id + 1'b1);
    end

    // Next-state logic: grant in IDLE, stream and release in LOCK.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant_id;
        w_burst_nxt = r_burst_cnt;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    w_state_nxt = ST_LOCK;
                    w_grant_nxt = w_pick;
                    w_burst_nxt = {CW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCK: begin
                w_xfer = w_g_valid & ~i_fifo_full;
                if (!w_g_valid ||
                    (w_xfer && (w_g_last || r_burst_cnt == CW'(MAX_BURST - 1)))) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_rr_inc;
                    w_burst_nxt = {CW{1'b0}};
                end else if (w_xfer) begin
                    w_burst_nxt = CW'(r_burst_cnt + 1'b1);
                end else begin
                    // FIFO stall: grant and burst count are frozen, no timeout.
                    w_burst_nxt = r_burst_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= {IDW{1'b0}};
            r_grant_id  <= {IDW{1'b0}};
            r_burst_cnt <= {CW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant_id  <= w_grant_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Output drive; everything is held at zero while reset is asserted.
    always_comb begin
        o_req_ready = {N{1'b0}};
        o_fifo_enq  = 1'b0;
        o_fifo_din  = {(WIDTH + IDW){1'b0}};
        o_grant_id  = {IDW{1'b0}};
        o_busy      = 1'b0;
        if (rst) begin
            o_busy = 1'b0;
        end else begin
            o_grant_id = r_grant_id;
            o_busy     = (r_state == ST_LOCK);
            o_fifo_enq = w_xfer;
            if ((r_state == ST_LOCK) && !i_fifo_full) begin
                o_req_ready = {{(N - 1){1'b0}}, 1'b1} << r_grant_id;
            end else begin
                o_req_ready = {N{1'b0}};
            end
            if (w_xfer) begin
                o_fifo_din = {r_grant_id, w_g_data};
            end else begin
                o_fifo_din = {(WIDTH + IDW){1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_writer_arb.sv
// Directed bench for fifo_rr_writer_arb (N=4, WIDTH=32, MAX_BURST=8).
module tb_fifo_rr_writer_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid;
    logic [127:0] data;
    logic [3:0]   last;
    logic [3:0]   ready;
    logic         enq;
    logic [33:0]  din;
    logic         full;
    logic [1:0]   gid;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_rr_writer_arb #(.N(4), .WIDTH(32), .MAX_BURST(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (valid),
        .i_req_data  (data),
        .i_req_last  (last),
        .o_req_ready (ready),
        .o_fifo_enq  (enq),
        .o_fifo_din  (din),
        .i_fifo_full (full),
        .o_grant_id  (gid),
        .o_busy      (busy)
    );

    function automatic logic [63:0] mk(input int id, input logic [31:0] d);
        return (64'(id) << 32) | {32'd0, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic e_enq, input logic e_busy,
                           input logic [3:0] e_rdy);
        chk({tag, "_enq"},   64'(enq),   64'(e_enq));
        chk({tag, "_busy"},  64'(busy),  64'(e_busy));
        chk({tag, "_ready"}, 64'(ready), 64'(e_rdy));
    endtask

    initial begin
        int          w;
        int          g;
        logic        e;
        logic [31:0] d;

        rst   = 1'b1;
        valid = 4'hF;
        last  = 4'h0;
        data  = 128'd0;
        full  = 1'b0;

        // 1: reset with all requesters valid
        @(negedge clk); #1;
        chk_ctl("t1_rst", 1'b0, 1'b0, 4'b0000);
        chk("t1_rst_gid", 64'(gid), 64'd0);
        chk("t1_rst_din", 64'(din), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctl("t1_idle", 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        valid = 4'h0;
        #1;
        chk("t1_first_gid", 64'(gid), 64'd0);
        chk_ctl("t1_lock_idle", 1'b0, 1'b1, 4'b0001);

        // 2: req0 sends three words, last on the third
        @(negedge clk);
        valid = 4'b0001;
        data[31:0] = 32'hA000_0000;
        #1;
        chk_ctl("t2_idle", 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data[31:0] = 32'hA000_0000 + 32'(i);
            last[0]    = (i == 2);
            #1;
            chk_ctl("t2_word", 1'b1, 1'b1, 4'b0001);
            chk("t2_din", 64'(din), mk(0, 32'hA000_0000 + 32'(i)));
        end
        @(negedge clk);
        valid = 4'h0;
        last  = 4'h0;
        #1;
        chk_ctl("t2_done", 1'b0, 1'b0, 4'b0000);

        // 3: req1 streams 20 words without last; bursts capped at 8
        w = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            valid = (w < 20) ? 4'b0010 : 4'b0000;
            d = 32'h1000_0000 + 32'(w);
            data[63:32] = d;
            #1;
            if (c == 23) begin
                chk_ctl("t3_drop", 1'b0, 1'b1, 4'b0010);
            end else if (c == 24) begin
                chk_ctl("t3_end", 1'b0, 1'b0, 4'b0000);
            end else begin
                e = !(c == 0 || c == 9 || c == 18);
                chk_ctl("t3", e, e, e ? 4'b0010 : 4'b0000);
                if (e) chk("t3_din", 64'(din), mk(1, d));
                if (c > 0) chk("t3_gid", 64'(gid), 64'd1);
                if (e) w++;
            end
        end

        // reset in IDLE to bring the pointer back to 0
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_ctl("t4_rst", 1'b0, 1'b0, 4'b0000);

        // 4: all four valid with one-word packets -> 0,1,2,3,0,1
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst   = 1'b0;
            valid = 4'hF;
            last  = 4'hF;
            for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'h4000_0000 | 32'(k << 8) | 32'(i);
            #1;
            chk_ctl("t4_idle", 1'b0, 1'b0, 4'b0000);
            @(negedge clk);
            #1;
            g = k % 4;
            chk("t4_gid", 64'(gid), 64'(g));
            chk_ctl("t4_word", 1'b1, 1'b1, 4'(1 << g));
            chk("t4_din", 64'(din), mk(g, 32'h4000_0000 | 32'(k << 8) | 32'(g)));
        end

        // 5: req2 burst with a 5-cycle FIFO stall; cap still lands on the 8th word
        w = 0;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            last  = 4'h0;
            valid = (c <= 14) ? 4'b0100 : 4'b0000;
            full  = (c >= 3 && c <= 7);
            d = 32'h5000_0000 + 32'(w);
            data[95:64] = d;
            #1;
            e = (c >= 1 && c <= 13) && !full;
            chk_ctl("t5", e, (c >= 1 && c <= 13) || c == 15,
                    ((c >= 1 && c <= 13) || c == 15) && !full ? 4'b0100 : 4'b0000);
            if (e) chk("t5_din", 64'(din), mk(2, d));
            if (c >= 1 && c <= 13) chk("t5_gid", 64'(gid), 64'd2);
            if (e) w++;
        end
        full = 1'b0;

        // 6: req3 goes idle after two words, then reset mid-burst
        @(negedge clk);
        valid = 4'b1000;
        data[127:96] = 32'h6000_0000;
        #1;
        chk_ctl("t6_idle0", 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data[127:96] = 32'h6000_0000 + 32'(i);
            #1;
            chk("t6_gid3", 64'(gid), 64'd3);
            chk_ctl("t6_word", 1'b1, 1'b1, 4'b1000);
            chk("t6_din", 64'(din), mk(3, 32'h6000_0000 + 32'(i)));
        end
        @(negedge clk);
        valid = 4'b0010;
        last  = 4'b0010;
        data[63:32] = 32'h7000_0000;
        #1;
        chk_ctl("t6_drop", 1'b0, 1'b1, 4'b1000);
        chk("t6_drop_gid", 64'(gid), 64'd3);
        @(negedge clk); #1;
        chk_ctl("t6_idle1", 1'b0, 1'b0, 4'b0000);
        @(negedge clk); #1;
        chk("t6_next_gid", 64'(gid), 64'd1);
        chk("t6_next_din", 64'(din), mk(1, 32'h7000_0000));
        @(negedge clk);
        valid = 4'b1010;
        last  = 4'b0000;
        data[127:96] = 32'h6000_0002;
        data[63:32]  = 32'h7000_0001;
        #1;
        chk_ctl("t6_idle2", 1'b0, 1'b0, 4'b0000);
        @(negedge clk); #1;
        chk("t6_gid3b", 64'(gid), 64'd3);
        chk("t6_din3b", 64'(din), mk(3, 32'h6000_0002));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_ctl("t6_rst", 1'b0, 1'b0, 4'b0000);
        chk("t6_rst_din", 64'(din), 64'd0);
        chk("t6_rst_gid", 64'(gid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctl("t6_post_rst", 1'b0, 1'b0, 4'b0000);
        @(negedge clk); #1;
        chk("t6_ptr0_gid", 64'(gid), 64'd1);
        chk("t6_ptr0_din", 64'(din), mk(1, 32'h7000_0001));
        valid = 4'h0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
